// File: rtl/checker_pkg.sv
// Shared types and helpers for the multi-channel behavioural-vs-netlist output checker.
package checker_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FAIL  = 2'd2
  } chk_state_e;

  // Width needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/checker_lane.sv
// One compared channel: equality test plus a run counter of consecutive enabled mismatches.
module checker_lane
  import checker_pkg::*;
#(
  parameter int W    = 8,
  parameter int SKEW = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         clear,
  input  logic [W-1:0] data_c,
  input  logic [W-1:0] data_e,
  output logic         eq,
  output logic         fail
);

  localparam int RUN_W = $clog2(SKEW + 2);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(SKEW);

  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;

  // An if on an unknown compare takes the else branch, so X/Z data reads as unequal.
  always_comb begin
    eq = 1'b0;
    if (data_c == data_e) eq = 1'b1;
  end

  assign fail  = enable && !eq && (run_q == RUN_LIM);
  assign run_d = RUN_W'(sat_inc(32'(run_q), 32'(SKEW + 1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= '0;
    end else if (clear) begin
      run_q <= '0;
    end else if (enable) begin
      if (eq) run_q <= '0;
      else    run_q <= run_d;
    end
  end

endmodule

// File: rtl/checker_cmp_n.sv
// NCH-channel output checker: arms on first full agreement, latches the first failure, keeps saturating statistics.
module checker_cmp_n
  import checker_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int W     = 8,
  parameter  int SKEW  = 0,
  parameter  int CNT_W = 16,
  localparam int CH_W  = clog2_min1(NCH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [NCH*W-1:0]   data_c,
  input  logic [NCH*W-1:0]   data_e,
  output logic               check_ok,
  output logic               err_sticky,
  output logic [NCH-1:0]     err_ch_mask,
  output logic [CH_W-1:0]    first_err_ch,
  output logic [CNT_W-1:0]   first_err_cyc,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [CNT_W-1:0]   mis_cnt,
  output logic [1:0]         state
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [NCH-1:0] eq_vec;
  logic [NCH-1:0] fail_vec;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    checker_lane #(
      .W    (W),
      .SKEW (SKEW)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (clear),
      .data_c (data_c[g*W +: W]),
      .data_e (data_e[g*W +: W]),
      .eq     (eq_vec[g]),
      .fail   (fail_vec[g])
    );
  end

  chk_state_e       state_q;
  logic             check_ok_q;
  logic             err_sticky_q;
  logic [NCH-1:0]   err_mask_q;
  logic [CH_W-1:0]  first_ch_q;
  logic [CNT_W-1:0] first_cyc_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] mis_q;
  logic [CNT_W-1:0] cyc_d;
  logic [CNT_W-1:0] mis_d;

  logic            all_eq;
  logic            any_fail;
  logic            count_en;
  logic [CH_W-1:0] low_idx;

  assign all_eq   = &eq_vec;
  assign any_fail = |fail_vec;
  // The arming cycle itself is the first counted compare cycle.
  assign count_en = enable && ((state_q != ST_WAIT) || all_eq);
  assign cyc_d    = CNT_W'(sat_inc(32'(cyc_q), CNT_MAX));
  assign mis_d    = CNT_W'(sat_inc(32'(mis_q), CNT_MAX));

  always_comb begin
    low_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (fail_vec[i]) low_idx = CH_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_WAIT;
      check_ok_q   <= 1'b1;
      err_sticky_q <= 1'b0;
      err_mask_q   <= '0;
      first_ch_q   <= '0;
      first_cyc_q  <= '0;
      cyc_q        <= '0;
      mis_q        <= '0;
    end else if (clear) begin
      state_q      <= ST_WAIT;
      check_ok_q   <= 1'b1;
      err_sticky_q <= 1'b0;
      err_mask_q   <= '0;
      first_ch_q   <= '0;
      first_cyc_q  <= '0;
      cyc_q        <= '0;
      mis_q        <= '0;
    end else begin
      if (enable)              check_ok_q <= all_eq;
      if (count_en)            cyc_q      <= cyc_d;
      if (count_en && !all_eq) mis_q      <= mis_d;
      case (state_q)
        ST_WAIT: begin
          if (enable && all_eq) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (any_fail) begin
            state_q      <= ST_FAIL;
            err_sticky_q <= 1'b1;
            first_ch_q   <= low_idx;
            first_cyc_q  <= cyc_q;
            err_mask_q   <= err_mask_q | fail_vec;
          end
        end
        ST_FAIL: begin
          err_mask_q <= err_mask_q | fail_vec;
        end
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  assign check_ok      = check_ok_q;
  assign err_sticky    = err_sticky_q;
  assign err_ch_mask   = err_mask_q;
  assign first_err_ch  = first_ch_q;
  assign first_err_cyc = first_cyc_q;
  assign cyc_cnt       = cyc_q;
  assign mis_cnt       = mis_q;
  assign state         = state_q;

endmodule

// File: tb/tb_checker_cmp_n.sv
// Directed bench for checker_cmp_n: three instances (SKEW=0, SKEW=2, CNT_W=4) share one stimulus stream.
module tb_checker_cmp_n;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [31:0] data_c;
  logic [31:0] data_e;

  logic        o0_ok, o0_sticky;
  logic [3:0]  o0_mask;
  logic [1:0]  o0_fch, o0_st;
  logic [15:0] o0_fcyc, o0_cyc, o0_mis;

  logic        o2_ok, o2_sticky;
  logic [3:0]  o2_mask;
  logic [1:0]  o2_fch, o2_st;
  logic [15:0] o2_fcyc, o2_cyc, o2_mis;

  logic        o4_ok, o4_sticky;
  logic [3:0]  o4_mask;
  logic [1:0]  o4_fch, o4_st;
  logic [3:0]  o4_fcyc, o4_cyc, o4_mis;

  checker_cmp_n #(.NCH(4), .W(8), .SKEW(0), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .data_c(data_c), .data_e(data_e),
    .check_ok(o0_ok), .err_sticky(o0_sticky), .err_ch_mask(o0_mask),
    .first_err_ch(o0_fch), .first_err_cyc(o0_fcyc),
    .cyc_cnt(o0_cyc), .mis_cnt(o0_mis), .state(o0_st)
  );

  checker_cmp_n #(.NCH(4), .W(8), .SKEW(2), .CNT_W(16)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .data_c(data_c), .data_e(data_e),
    .check_ok(o2_ok), .err_sticky(o2_sticky), .err_ch_mask(o2_mask),
    .first_err_ch(o2_fch), .first_err_cyc(o2_fcyc),
    .cyc_cnt(o2_cyc), .mis_cnt(o2_mis), .state(o2_st)
  );

  checker_cmp_n #(.NCH(4), .W(8), .SKEW(0), .CNT_W(4)) u4 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .data_c(data_c), .data_e(data_e),
    .check_ok(o4_ok), .err_sticky(o4_sticky), .err_ch_mask(o4_mask),
    .first_err_ch(o4_fch), .first_err_cyc(o4_fcyc),
    .cyc_cnt(o4_cyc), .mis_cnt(o4_mis), .state(o4_st)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // First-failure report for the SKEW=0 instance.
  always @(posedge o0_sticky) begin
    $display("u0 first error at %0t channel %0d", $time, o0_fch);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic clr, input logic [31:0] dc, input logic [31:0] de);
    enable = en;
    clear  = clr;
    data_c = dc;
    data_e = de;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic        clr;
    logic [31:0] dc;
    logic [31:0] de;
    logic [1:0]  st;
    logic        ok;
    logic        sticky;
    logic [3:0]  mask;
    logic [1:0]  fch;
    logic [15:0] fcyc;
    logic [15:0] cyc;
    logic [15:0] mis;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  logic [31:0] a_w, b_w, r_w;

  initial begin
    a_w = 32'h1122_3344;
    b_w = 32'hdead_beef;
    //          en    clr   dc                        de             st ok sk mask     fch fcyc cyc mis
    vecs[0]  = '{1'b0, 1'b0, a_w,                      a_w,           0, 1, 0, 4'b0000, 0, 0, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, a_w,                      32'h1122_3345, 0, 0, 0, 4'b0000, 0, 0, 0, 0};
    vecs[2]  = '{1'b1, 1'b0, a_w,                      a_w,           1, 1, 0, 4'b0000, 0, 0, 1, 0};
    vecs[3]  = '{1'b1, 1'b0, b_w,                      b_w,           1, 1, 0, 4'b0000, 0, 0, 2, 0};
    vecs[4]  = '{1'b0, 1'b0, b_w,                      32'h0,         1, 1, 0, 4'b0000, 0, 0, 2, 0};
    vecs[5]  = '{1'b1, 1'b0, 32'h00aa_0000,            32'h00bb_0000, 2, 0, 1, 4'b0100, 2, 2, 3, 1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0100_0001,            32'h0,         2, 0, 1, 4'b1101, 2, 2, 4, 2};
    vecs[7]  = '{1'b1, 1'b0, 32'h0100_0001,            32'h0,         2, 0, 1, 4'b1101, 2, 2, 5, 3};
    vecs[8]  = '{1'b1, 1'b0, a_w,                      a_w,           2, 1, 1, 4'b1101, 2, 2, 6, 3};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0100,            32'h0,         0, 1, 0, 4'b0000, 0, 0, 0, 0};
    vecs[10] = '{1'b1, 1'b0, a_w,                      a_w,           1, 1, 0, 4'b0000, 0, 0, 1, 0};
    vecs[11] = '{1'b1, 1'b0, 32'h0100_0001,            32'h0,         2, 0, 1, 4'b1001, 0, 1, 2, 1};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0100,            32'h0,         2, 0, 1, 4'b1011, 0, 1, 3, 2};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_0100,            32'h0,         0, 1, 0, 4'b0000, 0, 0, 0, 0};
    vecs[14] = '{1'b1, 1'b0, {4{8'bx0x0_1111}},        32'h0,         0, 0, 0, 4'b0000, 0, 0, 0, 0};
    vecs[15] = '{1'b1, 1'b0, a_w,                      a_w,           1, 1, 0, 4'b0000, 0, 0, 1, 0};
    vecs[16] = '{1'b1, 1'b1, 32'h0011_0000,            32'h0,         0, 1, 0, 4'b0000, 0, 0, 0, 0};
    vecs[17] = '{1'b0, 1'b0, a_w,                      a_w,           0, 1, 0, 4'b0000, 0, 0, 0, 0};
  end

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst.state",  32'(o0_st),     32'd0);
    chk("rst.ok",     32'(o0_ok),     32'd1);
    chk("rst.sticky", 32'(o0_sticky), 32'd0);
    chk("rst.cyc",    32'(o0_cyc),    32'd0);
    chk("rst.mis",    32'(o0_mis),    32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].dc, vecs[i].de);
      tick();
      chk($sformatf("v%0d.state", i),  32'(o0_st),     32'(vecs[i].st));
      chk($sformatf("v%0d.ok", i),     32'(o0_ok),     32'(vecs[i].ok));
      chk($sformatf("v%0d.sticky", i), 32'(o0_sticky), 32'(vecs[i].sticky));
      chk($sformatf("v%0d.mask", i),   32'(o0_mask),   32'(vecs[i].mask));
      chk($sformatf("v%0d.fch", i),    32'(o0_fch),    32'(vecs[i].fch));
      chk($sformatf("v%0d.fcyc", i),   32'(o0_fcyc),   32'(vecs[i].fcyc));
      chk($sformatf("v%0d.cyc", i),    32'(o0_cyc),    32'(vecs[i].cyc));
      chk($sformatf("v%0d.mis", i),    32'(o0_mis),    32'(vecs[i].mis));
    end

    // 20 identical random enabled cycles from WAIT.
    drive(1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    for (int k = 0; k < 20; k++) begin
      r_w = $urandom;
      drive(1'b1, 1'b0, r_w, r_w);
      tick();
    end
    chk("rand.state",  32'(o0_st),     32'd1);
    chk("rand.ok",     32'(o0_ok),     32'd1);
    chk("rand.cyc",    32'(o0_cyc),    32'd20);
    chk("rand.mis",    32'(o0_mis),    32'd0);
    chk("rand.sticky", 32'(o0_sticky), 32'd0);

    // Channel 2 differs at the 10th enabled cycle after arming.
    drive(1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    for (int k = 0; k < 9; k++) begin
      r_w = $urandom;
      drive(1'b1, 1'b0, r_w, r_w);
      tick();
    end
    r_w = $urandom;
    drive(1'b1, 1'b0, r_w, r_w ^ 32'h0001_0000);
    tick();
    chk("ch2.sticky", 32'(o0_sticky), 32'd1);
    chk("ch2.fch",    32'(o0_fch),    32'd2);
    chk("ch2.fcyc",   32'(o0_fcyc),   32'd9);
    chk("ch2.mask",   32'(o0_mask),   32'b0100);
    chk("ch2.state",  32'(o0_st),     32'd2);

    // SKEW=2 instance: two-cycle mismatch tolerated, three-cycle mismatch fails.
    drive(1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b0, a_w, a_w);
    tick();
    drive(1'b1, 1'b0, a_w, a_w ^ 32'h0000_0100);
    tick();
    tick();
    drive(1'b1, 1'b0, a_w, a_w);
    tick();
    chk("skew.short.state",  32'(o2_st),     32'd1);
    chk("skew.short.sticky", 32'(o2_sticky), 32'd0);
    chk("skew.short.mis",    32'(o2_mis),    32'd2);
    drive(1'b1, 1'b0, a_w, a_w ^ 32'h0000_0100);
    tick();
    tick();
    chk("skew.two.sticky", 32'(o2_sticky), 32'd0);
    chk("skew.two.state",  32'(o2_st),     32'd1);
    tick();
    chk("skew.three.sticky", 32'(o2_sticky), 32'd1);
    chk("skew.three.state",  32'(o2_st),     32'd2);
    chk("skew.three.fch",    32'(o2_fch),    32'd1);
    chk("skew.three.fcyc",   32'(o2_fcyc),   32'd6);
    chk("skew.three.mask",   32'(o2_mask),   32'b0010);
    chk("skew.three.mis",    32'(o2_mis),    32'd5);

    // CNT_W=4 instance: counters saturate at 15.
    drive(1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b0, b_w, b_w);
    tick();
    drive(1'b1, 1'b0, b_w, ~b_w);
    for (int k = 0; k < 20; k++) tick();
    chk("sat.state", 32'(o4_st),  32'd2);
    chk("sat.mis",   32'(o4_mis), 32'd15);
    chk("sat.cyc",   32'(o4_cyc), 32'd15);

    // Asynchronous reset mid-cycle, checked before the next rising edge.
    #2;
    reset = 1'b1;
    #1;
    chk("areset.state",  32'(o4_st),     32'd0);
    chk("areset.ok",     32'(o4_ok),     32'd1);
    chk("areset.sticky", 32'(o4_sticky), 32'd0);
    chk("areset.mask",   32'(o4_mask),   32'd0);
    chk("areset.cyc",    32'(o4_cyc),    32'd0);
    chk("areset.mis",    32'(o4_mis),    32'd0);
    chk("areset.fcyc",   32'(o4_fcyc),   32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
